// File: rtl/multicycle_ctrl_if.sv
// Handshake / control bundle between the multi-cycle controller and the RV32I datapath.
// master: the controller (reads instruction and status, drives control).
// slave:  the datapath side (drives instruction and status, reads control).
interface multicycle_ctrl_if;
    logic [31:0] inInstr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        alu_zero;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic [1:0]  imm_sel;
    logic        alu_src_imm;
    logic [1:0]  alu_op;
    logic        dmem_read;
    logic        dmem_write;
    logic        reg_write;
    logic        wb_sel;
    logic [2:0]  state;
    logic        illegal;

    modport master (
        input  inInstr, imem_ready, dmem_ready, alu_zero,
        output imem_req, ir_write, pc_write, pc_src, imm_sel, alu_src_imm,
               alu_op, dmem_read, dmem_write, reg_write, wb_sel, state, illegal
    );

    modport slave (
        output inInstr, imem_ready, dmem_ready, alu_zero,
        input  imem_req, ir_write, pc_write, pc_src, imm_sel, alu_src_imm,
               alu_op, dmem_read, dmem_write, reg_write, wb_sel, state, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Outputs are combinational from the state register and the live instruction word;
// the instruction is not latched here, the datapath holds it stable in the IR.
// Optional feature macro: ILLEGAL_TRAP_EN -- unsupported instructions lock the FSM
// in TRAP with a sticky illegal flag; when undefined they retire as a NOP.
module multicycle_ctrl (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_ctrl_if.master       bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t      state_r;
    state_t      next_state_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        is_r_s;
    logic        is_ialu_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        is_branch_s;
    logic        legal_s;
    logic [1:0]  imm_sel_s;
    logic        illegal_s;

    assign opcode_s = bus.inInstr[6:0];
    assign funct3_s = bus.inInstr[14:12];

    // Classify the live instruction word into one of the supported classes.
    always_comb begin
        is_r_s      = 1'b0;
        is_ialu_s   = 1'b0;
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        is_branch_s = 1'b0;
        case (opcode_s)
            OP_R:      is_r_s     = 1'b1;
            OP_IALU:   is_ialu_s  = 1'b1;
            OP_LOAD:   is_load_s  = 1'b1;
            OP_STORE:  is_store_s = 1'b1;
            OP_BRANCH: begin
                // only BEQ (000) and BNE (001) are implemented
                if (funct3_s[2:1] == 2'b00) begin
                    is_branch_s = 1'b1;
                end else begin
                    is_branch_s = 1'b0;
                end
            end
            default:   is_r_s     = 1'b0;
        endcase
        legal_s = is_r_s | is_ialu_s | is_load_s | is_store_s | is_branch_s;
        if (is_store_s) begin
            imm_sel_s = 2'b01;
        end else if (is_branch_s) begin
            imm_sel_s = 2'b10;
        end else begin
            imm_sel_s = 2'b00;
        end
    end

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky illegal flag, set on entry to TRAP and cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_r <= 1'b0;
        end else if (next_state_s == S_TRAP) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal_s = illegal_r;
`else
    assign illegal_s = 1'b0;
`endif

    // Next-state sequencing per instruction class and handshake.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (TRAP_EN && !legal_s) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_r_s || is_ialu_s) begin
                    next_state_s = S_WB;
                end else if (is_load_s || is_store_s) begin
                    next_state_s = S_MEM;
                end else begin
                    // branches and NOP-treated instructions retire here
                    next_state_s = S_FETCH;
                end
            end
            S_MEM: begin
                if (!bus.dmem_ready) begin
                    next_state_s = S_MEM;
                end else if (is_load_s) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_WB:    next_state_s = S_FETCH;
            S_TRAP:  next_state_s = S_TRAP;
            default: next_state_s = S_FETCH;
        endcase
    end

    // Control outputs decoded from state and instruction; forced low during reset.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 1'b0;
        bus.imm_sel     = 2'b00;
        bus.alu_src_imm = 1'b0;
        bus.alu_op      = 2'b00;
        bus.dmem_read   = 1'b0;
        bus.dmem_write  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.wb_sel      = 1'b0;
        bus.state       = state_r;
        bus.illegal     = illegal_s;
        if (rst) begin
            bus.state   = 3'd0;
            bus.illegal = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_write = bus.imem_ready;
                end
                S_DECODE: begin
                    bus.imm_sel = imm_sel_s;
                end
                S_EXEC: begin
                    bus.imm_sel = imm_sel_s;
                    if (is_r_s) begin
                        bus.alu_op = 2'b10;
                    end else if (is_ialu_s) begin
                        bus.alu_op      = 2'b10;
                        bus.alu_src_imm = 1'b1;
                    end else if (is_load_s || is_store_s) begin
                        bus.alu_op      = 2'b00;
                        bus.alu_src_imm = 1'b1;
                    end else if (is_branch_s) begin
                        bus.alu_op   = 2'b01;
                        bus.pc_write = 1'b1;
                        // funct3[0]: 0 = BEQ (taken on zero), 1 = BNE (taken on non-zero)
                        bus.pc_src   = bus.alu_zero ^ funct3_s[0];
                    end else begin
                        bus.pc_write = 1'b1;
                    end
                end
                S_MEM: begin
                    bus.imm_sel = imm_sel_s;
                    if (is_load_s) begin
                        bus.dmem_read = 1'b1;
                    end else if (is_store_s) begin
                        bus.dmem_write = 1'b1;
                        bus.pc_write   = bus.dmem_ready;
                    end else begin
                        bus.dmem_read = 1'b0;
                    end
                end
                S_WB: begin
                    bus.imm_sel   = imm_sel_s;
                    bus.reg_write = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.wb_sel    = is_load_s;
                end
                S_TRAP: begin
                    bus.imm_sel = 2'b00;
                end
                default: begin
                    bus.imm_sel = 2'b00;
                end
            endcase
        end
    end

endmodule
